// File: rtl/an_code_pkg.sv
// Shared constants, FSM state type and reference codeword function for the AN-code encoder.
package an_code_pkg;
  localparam int A    = 37;
  localparam int A_W  = 6;
  localparam int N_W  = 12;
  localparam int AN_W = 18;

  localparam int IDX_W = $clog2(A_W);
  localparam int EP_W  = $clog2(AN_W);

  localparam logic [A_W-1:0] A_VEC = A_W'(A);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  function automatic logic [AN_W-1:0] an_ref(input logic [N_W-1:0] n);
    return AN_W'(A) * AN_W'(n);
  endfunction
endpackage

// File: rtl/an_shift_add_core.sv
// Iterative shift-add multiplier: one bit of A per clock, LSB first, starting on a start strobe.
module an_shift_add_core
  import an_code_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N_W-1:0]  n_in,
  output logic [AN_W-1:0] sum,
  output logic            last,
  output logic [N_W-1:0]  mcand
);
  logic [N_W-1:0]   n_reg;
  logic [AN_W-1:0]  acc_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             run_reg;
  logic [AN_W-1:0]  terms [A_W];

  // Partial products are fixed by A, so only the set bits produce a shifted copy of N.
  generate
    for (genvar gi = 0; gi < A_W; gi++) begin : g_term
      assign terms[gi] = A_VEC[gi] ? (AN_W'(n_reg) << gi) : '0;
    end
  endgenerate

  assign sum   = acc_reg + terms[idx_reg];
  assign last  = run_reg && (idx_reg == IDX_W'(A_W - 1));
  assign mcand = n_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_reg   <= '0;
      acc_reg <= '0;
      idx_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      n_reg   <= n_in;
      acc_reg <= '0;
      idx_reg <= '0;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      acc_reg <= sum;
      if (last) run_reg <= 1'b0;
      else      idx_reg <= idx_reg + IDX_W'(1);
    end
  end
endmodule

// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder (AN = A*N) with valid/ready handshakes on both sides.
// Optional single-error injection is enabled by defining AN_ENC_FAULT_INJ_EN.
module an_encoder_seq
  import an_code_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_W-1:0]  N_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AN_W-1:0] AN_out,
  output logic            busy
`ifdef AN_ENC_FAULT_INJ_EN
  ,
  input  logic            err_en,
  input  logic            err_sign,
  input  logic [EP_W-1:0] err_pos
`endif
);
  generate
    if (AN_W < N_W + A_W) begin : g_bad_an_w
      $error("AN_W must be at least N_W + A_W");
    end
    if ((A % 2) == 0 || A <= 1) begin : g_bad_a
      $error("A must be odd and greater than 1");
    end
    if (A < (1 << (A_W - 1)) || A >= (1 << A_W)) begin : g_bad_a_w
      $error("A_W must be the exact bit width of A");
    end
  endgenerate

  state_t          state;
  logic            start;
  logic [AN_W-1:0] core_sum;
  logic            core_last;
  logic [N_W-1:0]  core_mcand;
  logic [AN_W-1:0] coded;

  assign start = (state == IDLE) && in_valid && in_ready;

  an_shift_add_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n_in  (N_in),
    .sum   (core_sum),
    .last  (core_last),
    .mcand (core_mcand)
  );

`ifdef AN_ENC_FAULT_INJ_EN
  logic            err_en_reg;
  logic            err_sign_reg;
  logic [EP_W-1:0] err_pos_reg;
  logic [AN_W-1:0] inj;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_en_reg   <= 1'b0;
      err_sign_reg <= 1'b0;
      err_pos_reg  <= '0;
    end else if (start) begin
      err_en_reg   <= err_en;
      err_sign_reg <= err_sign;
      err_pos_reg  <= err_pos;
    end
  end

  // Positions beyond the codeword width inject nothing; add/subtract wrap modulo 2^AN_W.
  always_comb begin
    inj = '0;
    if (err_en_reg && (32'(err_pos_reg) < AN_W)) inj = AN_W'(1) << err_pos_reg;
    coded = err_sign_reg ? (core_sum - inj) : (core_sum + inj);
  end
`else
  assign coded = core_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      AN_out    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= MUL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL: begin
          if (core_last) begin
            state     <= DONE;
            AN_out    <= coded;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // The pre-injection product must always equal the reference codeword.
  a_product: assert property (@(posedge clk) disable iff (!rst_n)
    core_last |-> (core_sum == an_ref(core_mcand)));
endmodule

// File: tb/tb_an_encoder_seq.sv
// Randomized self-checking bench for an_encoder_seq; fault-injection cases run when AN_ENC_FAULT_INJ_EN is defined.
module tb_an_encoder_seq;
  import an_code_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [N_W-1:0]  N_in = '0;
  logic            in_ready;
  logic            out_valid;
  logic            busy;
  logic [AN_W-1:0] AN_out;
`ifdef AN_ENC_FAULT_INJ_EN
  logic            err_en = 1'b0;
  logic            err_sign = 1'b0;
  logic [EP_W-1:0] err_pos = '0;
`endif

  int checks = 0;
  int failures = 0;

  an_encoder_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N_in      (N_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .AN_out    (AN_out),
    .busy      (busy)
`ifdef AN_ENC_FAULT_INJ_EN
    ,
    .err_en    (err_en),
    .err_sign  (err_sign),
    .err_pos   (err_pos)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; N_in = 12'd5; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (AN_out !== '0) begin failures++; $display("FAIL reset_an_out got=%0d exp=0", AN_out); end
    in_valid = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
  endtask

  // One word through the encoder with an optional output stall of 'stall' cycles.
  task automatic test_word(input logic [N_W-1:0] n, input int stall, input logic [AN_W-1:0] exp, input string name);
    int cnt;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_before got=%0b exp=1", name, in_ready); end
    N_in = n; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL %s_mul_flags got=%0b%0b exp=01", name, in_ready, busy); end
      in_valid = 1'($urandom); N_in = N_W'($urandom);
      tick(); cnt++;
    end
    in_valid = 1'b0;
    checks++; if (cnt !== A_W) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, cnt, A_W); end
    checks++; if (AN_out !== exp) begin failures++; $display("FAIL %s_an_out got=%0d exp=%0d", name, AN_out, exp); end
    for (int s = 0; s < stall; s++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || AN_out !== exp || in_ready !== 1'b0)
        begin failures++; $display("FAIL %s_stall%0d got=v%0b r%0b %0d exp=v1 r0 %0d", name, s, out_valid, in_ready, AN_out, exp); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL %s_release got=v%0b r%0b b%0b exp=v0 r1 b0", name, out_valid, in_ready, busy); end
    $display("word %s N=%0d AN=%0d", name, n, AN_out);
  endtask

  task automatic test_basic();
    logic [N_W-1:0] n;
    test_word(12'd0, 0, 18'd0, "n0");
    test_word(12'd1, 0, 18'd37, "n1");
    test_word(12'd4095, 0, 18'd151515, "n4095");
    for (int k = 0; k < 6; k++) begin
      n = N_W'($urandom);
      test_word(n, $urandom_range(0, 3), AN_W'(A * int'(n)), "rand");
    end
  endtask

  task automatic test_backpressure();
    test_word(12'd100, 10, 18'd3700, "bp100");
  endtask

  task automatic test_back_to_back();
    int q[$];
    int next_n = 1, got = 0, cyc = 0, last_cyc = -1, e;
    out_ready = 1'b1;
    while (got < 50 && cyc < 600) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL b2b_unexpected got=%0d exp=none", AN_out); end
        else begin
          e = q.pop_front();
          if (AN_out !== AN_W'(A * e)) begin failures++; $display("FAIL b2b_an_out got=%0d exp=%0d", AN_out, A * e); end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != A_W + 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - last_cyc, A_W + 2); end
        end
        last_cyc = cyc; got++;
      end
      if (in_ready === 1'b1) begin
        if (next_n <= 50) begin in_valid = 1'b1; N_in = N_W'(next_n); q.push_back(next_n); next_n++; end
        else in_valid = 1'b0;
      end else begin
        in_valid = 1'($urandom); N_in = N_W'($urandom);
      end
      tick(); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 50) begin failures++; $display("FAIL b2b_count got=%0d exp=50", got); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    N_in = N_W'($urandom); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mul_busy got=%0b exp=1", busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL rst_mul_idle got=v%0b b%0b r%0b exp=v0 b0 r1", out_valid, busy, in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || AN_out !== '0)
        begin failures++; $display("FAIL rst_mul_stale%0d got=v%0b %0d exp=v0 0", c, out_valid, AN_out); end
    end
    out_ready = 1'b0;
  endtask

`ifdef AN_ENC_FAULT_INJ_EN
  task automatic test_fault();
    err_en = 1'b1; err_sign = 1'b0; err_pos = 5'd3;
    test_word(12'd1, 0, 18'd45, "fault_add");
    err_sign = 1'b1;
    test_word(12'd1, 0, 18'd29, "fault_sub");
    err_pos = 5'd0;
    test_word(12'd0, 0, 18'd262143, "fault_wrap");
    err_en = 1'b1; err_sign = 1'b0; err_pos = 5'd20;
    test_word(12'd1, 0, 18'd37, "fault_pos_oob");
    err_en = 1'b0; err_pos = 5'd3;
    test_word(12'd1, 0, 18'd37, "fault_off");
    err_sign = 1'b0; err_pos = '0;
  endtask
`endif

  task automatic test_sweep();
    int q[$];
    int next_n = 0, got = 0, cyc = 0, e;
    while (got < 4096 && cyc < 60000) begin
      out_ready = 1'($urandom);
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL sweep_unexpected got=%0d exp=none", AN_out); end
        else begin
          e = q.pop_front();
          if (AN_out !== AN_W'(A * e)) begin failures++; $display("FAIL sweep_an_out N=%0d got=%0d exp=%0d", e, AN_out, A * e); end
        end
        checks++;
        if ((int'(AN_out) % A) != 0) begin failures++; $display("FAIL sweep_mod got=%0d exp=0", int'(AN_out) % A); end
        got++;
      end
      if (in_ready === 1'b1 && next_n < 4096) begin
        in_valid = 1'b1; N_in = N_W'(next_n); q.push_back(next_n); next_n++;
      end else begin
        in_valid = 1'b0;
      end
      tick(); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 4096) begin failures++; $display("FAIL sweep_count got=%0d exp=4096", got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
`ifdef AN_ENC_FAULT_INJ_EN
    test_fault();
`endif
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/an_encoder_seq.md
Name: an_encoder_seq

Overview:
Sequential AN-code encoder, the stage directly upstream of the AN decoder. It accepts an N_W-bit data word N over a valid/ready handshake and produces the AN_W-bit codeword AN = A*N for the storage or transmission channel. The product is computed with an iterative shift-add multiplier, one bit of A per clock. The codeword is held on a valid/ready output until the downstream stage consumes it.

Parameters:
- A, 37, AN-code multiplier. Odd, and greater than 1.
- A_W, 6, bit width of A. Must satisfy 2^(A_W-1) <= A < 2^A_W.
- N_W, 12, data word width.
- AN_W, 18, codeword width. Must satisfy AN_W >= N_W + A_W; elaboration-time check.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  N_in is valid.
- in_ready  out  1  encoder can accept a word.
- N_in  in  N_W  data word.
- out_valid  out  1  AN_out is valid.
- out_ready  in  1  downstream accepts AN_out.
- AN_out  out  AN_W  codeword.
- busy  out  1  high in MUL or DONE.

Behaviour:
- Reset, applied when rst_n=0 at a clk edge:
  - state goes to IDLE; accumulator and AN_out go to 0.
  - out_valid=0, busy=0, in_ready=1 (in_ready=1 in the cycle after reset).
  - Reset has priority over every other event, including an active handshake.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture N_in into the multiplicand register, clear the accumulator, set bit index i=0, go to MUL.
- MUL, one cycle per bit of A, LSB first:
  - If A[i]=1: acc <= acc + (N << i), computed at AN_W bits.
  - i increments each cycle; after the cycle with i = A_W-1, go to DONE.
  - The state lasts exactly A_W cycles. in_ready=0.
- DONE:
  - out_valid=1; AN_out holds the final value.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
  - in_ready=0 while in DONE; there is no same-cycle re-accept.
- Latency: acceptance edge at cycle 0, MUL occupies cycles 1..A_W, out_valid is first high in cycle A_W+1.
- Throughput: at most one word per A_W+2 cycles.
- Arithmetic: the product never exceeds (2^N_W - 1)*A < 2^AN_W, so no overflow is possible in the fault-free path.
- Stability: AN_out and out_valid stay stable while out_valid && !out_ready; in_valid toggling has no effect outside IDLE.
- Reset mid-MUL or mid-DONE: the word in flight is discarded and no output is produced.
- AN_out is registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: AN_ENC_FAULT_INJ_EN.
- With the macro defined, three extra inputs exist:
  - err_en (1 bit), err_sign (1 bit, 0 = add, 1 = subtract), err_pos ($clog2(AN_W) bits).
  - All three are captured together with N_in at acceptance.
  - On the MUL->DONE transition, if err_en=1: AN_out = acc +/- 2^err_pos, modulo 2^AN_W (wraps).
  - err_pos >= AN_W means no injection.
  - This models the single arithmetic error that the downstream decoder corrects.
- Without the macro: the three ports are absent and AN_out = A*N exactly.

Decomposition:
- Package an_code_pkg holds:
  - localparams A, A_W, N_W, AN_W;
  - the state enum typedef (IDLE/MUL/DONE);
  - a function computing the reference codeword, used by RTL assertions and the bench.
- One natural sub-module, an_shift_add_core: holds the multiplicand, accumulator and bit index, with start/done strobes. The top module owns the FSM, the handshakes and the fault injection.

Test Plan:
- Reset, then N_in=0 with in_valid=1: out_valid in cycle 7 (A_W+1), AN_out=0. N_in=1 -> 37. N_in=4095 -> 151515 (0x24FDB).
- Backpressure: N_in=100, out_ready held low for 10 cycles after out_valid -> AN_out=3700 stays stable and in_ready=0 throughout; out_ready=1 -> out_valid drops next cycle and in_ready returns to 1.
- Back-to-back stream of N=1..50 with in_valid and out_ready held high -> each AN_out = 37*N, in order, one word per 8 cycles; in_valid changes during MUL/DONE are ignored.
- rst_n=0 during the third MUL cycle -> the next cycle shows IDLE with out_valid=0, busy=0, in_ready=1; no stale output appears afterwards.
- With AN_ENC_FAULT_INJ_EN:
  - N=1, err_pos=3, err_sign=0 -> AN_out=45 (45 mod 37 = 8); err_sign=1 -> AN_out=29.
  - N=0, err_pos=0, err_sign=1 -> AN_out=262143 (wraps).
  - err_en=0 -> AN_out=37.
- Sweep all 4096 values of N with random out_ready -> every AN_out matches the package reference function and AN_out mod 37 = 0.
